// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: picks what the two-digit display shows per game phase.
// Also tracks the session high score and sequences attract/over views.
module display_mode_ctrl #(
  parameter int          ALT_MS      = 2000,
  parameter int          BLINK_MS    = 250,
  parameter int          BLINK_COUNT = 4,
  parameter int          HOLD_MS     = 3000,
  parameter logic [7:0]  WARN_BCD    = 8'h05
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic       game_active,
  input  logic       game_over,
  input  logic [7:0] score_bcd,
  input  logic [7:0] time_bcd,
  output logic [7:0] disp_value,
  output logic       disp_blank,
  output logic [7:0] hi_score,
  output logic       new_record
);

  localparam int TMAX =
    (ALT_MS > BLINK_MS) ? ALT_MS : BLINK_MS;
  localparam int TW = $clog2(TMAX + 1);
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int CW = $clog2(BLINK_COUNT + 1);

  localparam logic [TW-1:0] ALT_LD = TW'(ALT_MS - 1);
  localparam logic [TW-1:0] BLK_LD = TW'(BLINK_MS - 1);
  localparam logic [HW-1:0] HLD_LD = HW'(HOLD_MS - 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(BLINK_COUNT - 1);

  typedef enum logic [1:0] {
    ATTRACT,
    PLAY,
    OVER_BLINK,
    OVER_HOLD
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [HW-1:0]   hold_cnt;
  logic [CW-1:0]   blink_cnt;
  logic            phase;
  logic [7:0]      final_reg;
  logic            warn;

  // Low-time warning: nonzero and at or below the threshold.
  assign warn = (time_bcd != 8'h00) &&
                (time_bcd <= WARN_BCD);

  // Phase sequencer; outputs registered from current state and inputs.
  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      state      <= ATTRACT;
      timer      <= '0;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      final_reg  <= 8'h00;
      hi_score   <= 8'h00;
      new_record <= 1'b0;
      disp_value <= 8'h00;
      disp_blank <= 1'b0;
    end else begin
      unique case (state)
        ATTRACT: begin
          disp_value <= phase ? final_reg : hi_score;
          disp_blank <= 1'b0;
          if (game_active) begin
            state      <= PLAY;
            new_record <= 1'b0;
            timer      <= BLK_LD;
            phase      <= 1'b0;
          end else if (timer == '0) begin
            phase <= ~phase;
            timer <= ALT_LD;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        PLAY: begin
          disp_value <= warn ? time_bcd : score_bcd;
          disp_blank <= warn & phase;
          if (game_over || !game_active) begin
            state     <= OVER_BLINK;
            final_reg <= score_bcd;
            if (score_bcd > hi_score) begin
              hi_score   <= score_bcd;
              new_record <= 1'b1;
            end
            timer     <= BLK_LD;
            phase     <= 1'b0;
            blink_cnt <= '0;
          end else if (!warn) begin
            timer <= BLK_LD;
            phase <= 1'b0;
          end else if (timer == '0) begin
            phase <= ~phase;
            timer <= BLK_LD;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        OVER_BLINK: begin
          disp_value <= final_reg;
          disp_blank <= phase;
          if (timer == '0) begin
            timer <= BLK_LD;
            phase <= ~phase;
            if (phase) begin
              if (blink_cnt == CNT_LAST) begin
                state    <= OVER_HOLD;
                hold_cnt <= HLD_LD;
              end else begin
                blink_cnt <= blink_cnt + CW'(1);
              end
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end

        OVER_HOLD: begin
          disp_value <= hi_score;
          disp_blank <= new_record & phase;
          if (game_active) begin
            state      <= PLAY;
            new_record <= 1'b0;
            timer      <= BLK_LD;
            phase      <= 1'b0;
          end else if (hold_cnt == '0) begin
            state <= ATTRACT;
            timer <= ALT_LD;
            phase <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
            if (timer == '0) begin
              phase <= ~phase;
              timer <= BLK_LD;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end

        default: begin
          state <= ATTRACT;
          timer <= ALT_LD;
          phase <= 1'b0;
        end
      endcase
    end
  end

endmodule
